// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: state encoding, reset/trap vectors
// and the NOP word. Decode and CSR logic import the same defaults.
package pc_fetch_unit_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;
  localparam logic [31:0] NOP_INSTR_DEF    = 32'h0000_0013; // addi x0,x0,0

  // A fetch target must be word aligned
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage : pc_fetch_unit_pkg

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address out, ack/data back.
// imem_ack is only meaningful while imem_req is high.
interface pc_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Fetch unit side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Instruction memory side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface : pc_fetch_unit_if

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Next-PC selection for the fetch unit. Purely combinational.
// Priority: live redirect > deferred (killed) redirect > sequential advance.
// Any loaded target is alignment-checked here; a misaligned one is replaced
// by the trap vector and flagged.
module pc_fetch_unit_pc_next_sel
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEF
) (
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_plus4,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  input  logic [31:0] i_redir_reg,
  input  logic        i_kill,
  input  logic        i_ack,
  input  logic        i_req,
  output logic [31:0] o_pc_next,
  output logic        o_trap
);

  logic        w_load;
  logic [31:0] w_target;

  // Choose between hold, advance and a target load, then vet the target
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_load    = 1'b0;
    w_target  = i_redirect_target;
    o_pc_next = i_pc;
    o_trap    = 1'b0;

    if (i_ack) begin
      if (i_redirect_valid) begin
        // Redirect arriving with the ack wins; the acked word is dropped
        w_load   = 1'b1;
        w_target = i_redirect_target;
      end else if (i_kill) begin
        // Outstanding access was killed earlier; go where it was redirected
        w_load   = 1'b1;
        w_target = i_redir_reg;
      end else begin
        o_pc_next = i_pc_plus4;
      end
    end else if (i_redirect_valid && !i_req) begin
      // Nothing on the bus, so the PC can move right away. With a request
      // outstanding the top latches the target instead and the PC holds to
      // keep imem_addr stable.
      w_load   = 1'b1;
      w_target = i_redirect_target;
    end

    if (w_load) begin
      if (is_misaligned(w_target)) begin
        o_pc_next = TRAP_VECTOR;
        o_trap    = 1'b1;
      end else begin
        o_pc_next = w_target;
      end
    end
  end

endmodule : pc_fetch_unit_pc_next_sel

// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer.
// Holds the architectural PC, fetches one word at a time over a req/ack bus
// and hands each instruction with its PC to decode. Redirects taken while an
// access is outstanding are deferred until that access completes.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEF,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_redirect_valid,
  input  logic [31:0]       i_redirect_target,
  input  logic              i_halt,
  pc_fetch_unit_if.master   imem,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_pc_plus4,
  output logic              o_instr_valid,
  output logic [31:0]       o_instr,
  output logic [31:0]       o_instr_pc,
  output logic              o_misalign_trap,
  output logic              o_halted
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic         r_pending;
  logic         r_kill;
  logic [31:0]  r_redir;
  logic         r_instr_valid;
  logic [31:0]  r_instr;
  logic [31:0]  r_instr_pc;
  logic         r_misalign_trap;
  logic         r_halted;

  logic         w_req;
  logic         w_ack;
  logic         w_pending_next;
  logic         w_deliver;
  logic         w_defer_redirect;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_pc_next;
  logic         w_trap;

  // Request is held while pending regardless of stall/halt; a new one starts
  // only when the back end can take it and no halt is requested.
  assign w_req            = (r_state == S_RUN) && (r_pending || (!i_stall && !i_halt));
  // Acks outside a request (e.g. late ones after reset) are ignored
  assign w_ack            = w_req && imem.imem_ack;
  assign w_pending_next   = w_req && !imem.imem_ack;
  assign w_deliver        = w_ack && !r_kill && !i_redirect_valid;
  assign w_defer_redirect = i_redirect_valid && w_pending_next;
  assign w_pc_plus4       = r_pc + 32'd4;

  pc_fetch_unit_pc_next_sel #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_pc_next_sel (
    .i_pc              (r_pc),
    .i_pc_plus4        (w_pc_plus4),
    .i_redirect_valid  (i_redirect_valid),
    .i_redirect_target (i_redirect_target),
    .i_redir_reg       (r_redir),
    .i_kill            (r_kill),
    .i_ack             (w_ack),
    .i_req             (w_req),
    .o_pc_next         (w_pc_next),
    .o_trap            (w_trap)
  );

  // Sequencer FSM: BOOT for one cycle, RUN until halt drains, HALT until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_BOOT;
      r_halted <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      case (r_state)
        S_BOOT: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (i_halt && !w_pending_next) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  // PC, handshake bookkeeping and registered decode-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc            <= RESET_VECTOR;
      r_pending       <= 1'b0;
      r_kill          <= 1'b0;
      r_instr_valid   <= 1'b0;
      r_instr         <= NOP_INSTR;
      r_instr_pc      <= 32'h0000_0000;
      r_misalign_trap <= 1'b0;
    end else begin
      r_pc            <= w_pc_next;
      r_pending       <= w_pending_next;
      r_misalign_trap <= w_trap;
      r_instr_valid   <= w_deliver;
      r_instr         <= w_deliver ? imem.imem_rdata : NOP_INSTR;
      if (w_deliver) begin
        r_instr_pc <= r_pc;
      end
      if (w_ack) begin
        r_kill <= 1'b0;
      end else if (w_defer_redirect) begin
        r_kill <= 1'b1;
      end
    end
  end

  // Deferred redirect target; last redirect before the ack wins
  always_ff @(posedge clk) begin
    // NOTE: no reset here -- r_redir is only consumed while r_kill=1, and reset clears r_kill.
    if (w_defer_redirect) begin
      r_redir <= i_redirect_target;
    end
  end

  assign imem.imem_req   = w_req;
  assign imem.imem_addr  = r_pc;

  assign o_pc            = r_pc;
  assign o_pc_plus4      = w_pc_plus4;
  assign o_instr_valid   = r_instr_valid;
  assign o_instr         = r_instr;
  assign o_instr_pc      = r_instr_pc;
  assign o_misalign_trap = r_misalign_trap;
  assign o_halted        = r_halted;

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit. Memory returns addr ^ 0xA5A5A5A5,
// either with ack tied to req (zero wait) or with a bench-controlled ack.
// Delivered instructions are checked by a scoreboard monitor; control and
// bus signals are checked directly from the stimulus thread.
module tb_pc_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        i_stall;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_target;
  logic        i_halt;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        o_misalign_trap;
  logic        o_halted;

  logic        tb_zero_wait;
  logic        tb_ack;

  int total = 0;
  int bad   = 0;
  exp_t sb_q[$];

  pc_fetch_unit_if imem_bus ();

  assign imem_bus.imem_ack   = tb_zero_wait ? imem_bus.imem_req : tb_ack;
  assign imem_bus.imem_rdata = imem_bus.imem_addr ^ 32'hA5A5_A5A5;

  pc_fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .i_stall           (i_stall),
    .i_redirect_valid  (i_redirect_valid),
    .i_redirect_target (i_redirect_target),
    .i_halt            (i_halt),
    .imem              (imem_bus),
    .o_pc              (o_pc),
    .o_pc_plus4        (o_pc_plus4),
    .o_instr_valid     (o_instr_valid),
    .o_instr           (o_instr),
    .o_instr_pc        (o_instr_pc),
    .o_misalign_trap   (o_misalign_trap),
    .o_halted          (o_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: sample away from the active edge
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (o_instr_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_instr_pc", o_instr_pc, 32'hxxxx_xxxx);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("instr_pc", o_instr_pc, e.pc);
          check("instr", o_instr, e.instr);
        end
      end else begin
        check("idle_instr_nop", o_instr, NOP);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    i_stall           = 1'b0;
    i_redirect_valid  = 1'b0;
    i_redirect_target = 32'h0;
    i_halt            = 1'b0;
    tb_zero_wait      = 1'b0;
    tb_ack            = 1'b0;

    // ---- Reset state ----
    tick();
    tick();
    @(negedge clk);
    check("rst_pc", o_pc, 32'h0);
    check("rst_instr_valid", 32'(o_instr_valid), 32'd0);
    check("rst_instr", o_instr, NOP);
    check("rst_instr_pc", o_instr_pc, 32'h0);
    check("rst_req", 32'(imem_bus.imem_req), 32'd0);
    check("rst_trap", 32'(o_misalign_trap), 32'd0);
    check("rst_halted", 32'(o_halted), 32'd0);

    // ---- Zero-wait streaming from reset ----
    tick();
    rst          = 1'b0;
    tb_zero_wait = 1'b1;
    push(32'h0000_0000, 32'hA5A5_A5A5);
    push(32'h0000_0004, 32'hA5A5_A5A1);
    push(32'h0000_0008, 32'hA5A5_A5AD);
    @(negedge clk);
    check("boot_req", 32'(imem_bus.imem_req), 32'd0);
    tick();
    @(negedge clk);
    check("first_req", 32'(imem_bus.imem_req), 32'd1);
    check("first_addr", imem_bus.imem_addr, 32'h0);
    tick();
    @(negedge clk);
    check("zw_valid0", 32'(o_instr_valid), 32'd1);
    tick();
    @(negedge clk);
    check("zw_valid1", 32'(o_instr_valid), 32'd1);
    tick();
    i_stall = 1'b1;
    @(negedge clk);
    check("zw_valid2", 32'(o_instr_valid), 32'd1);
    check("stall_no_req", 32'(imem_bus.imem_req), 32'd0);
    check("stall_pc", o_pc, 32'h0000_000C);
    tick();
    @(negedge clk);
    check("stall_pc_hold", o_pc, 32'h0000_000C);
    check("stall_no_valid", 32'(o_instr_valid), 32'd0);

    // ---- 3-cycle latency with stall pulsed mid-access ----
    tb_zero_wait      = 1'b0;
    tb_ack            = 1'b0;
    i_redirect_valid  = 1'b1;
    i_redirect_target = 32'h0000_0004;
    tick();
    i_redirect_valid = 1'b0;
    i_stall          = 1'b0;
    @(negedge clk);
    check("lat_req_c1", 32'(imem_bus.imem_req), 32'd1);
    check("lat_addr_c1", imem_bus.imem_addr, 32'h0000_0004);
    tick();
    i_stall = 1'b1;
    @(negedge clk);
    check("lat_req_stall", 32'(imem_bus.imem_req), 32'd1);
    check("lat_addr_stall", imem_bus.imem_addr, 32'h0000_0004);
    tick();
    i_stall = 1'b0;
    tb_ack  = 1'b1;
    push(32'h0000_0004, 32'hA5A5_A5A1);
    @(negedge clk);
    check("lat_addr_c3", imem_bus.imem_addr, 32'h0000_0004);
    tick();
    tb_ack = 1'b0;
    @(negedge clk);
    check("lat_pc_after", o_pc, 32'h0000_0008);

    // ---- Redirect while access to 0x8 pending ----
    tick();
    i_redirect_valid  = 1'b1;
    i_redirect_target = 32'h0000_0200;
    @(negedge clk);
    check("kill_addr_pend", imem_bus.imem_addr, 32'h0000_0008);
    tick();
    i_redirect_valid = 1'b0;
    tb_ack           = 1'b1;
    @(negedge clk);
    check("kill_req_held", 32'(imem_bus.imem_req), 32'd1);
    check("kill_addr_held", imem_bus.imem_addr, 32'h0000_0008);
    tick();
    tb_ack = 1'b0;
    @(negedge clk);
    check("kill_no_valid", 32'(o_instr_valid), 32'd0);
    check("kill_pc", o_pc, 32'h0000_0200);
    check("kill_next_addr", imem_bus.imem_addr, 32'h0000_0200);
    check("kill_next_req", 32'(imem_bus.imem_req), 32'd1);
    tb_ack = 1'b1;
    push(32'h0000_0200, 32'hA5A5_A7A5);
    tick();

    // ---- Misaligned redirect coincident with ack ----
    i_redirect_valid  = 1'b1;
    i_redirect_target = 32'h0000_0202;
    @(negedge clk);
    check("mis_addr", imem_bus.imem_addr, 32'h0000_0204);
    tick();
    i_redirect_valid = 1'b0;
    tb_ack           = 1'b0;
    i_stall          = 1'b1;
    @(negedge clk);
    check("mis_trap", 32'(o_misalign_trap), 32'd1);
    check("mis_no_valid", 32'(o_instr_valid), 32'd0);
    check("mis_pc", o_pc, 32'h0000_0100);
    tick();
    @(negedge clk);
    check("mis_trap_pulse", 32'(o_misalign_trap), 32'd0);
    i_stall = 1'b0;
    tb_ack  = 1'b1;
    push(32'h0000_0100, 32'hA5A5_A4A5);
    #1;
    check("trap_req", 32'(imem_bus.imem_req), 32'd1);
    check("trap_addr", imem_bus.imem_addr, 32'h0000_0100);
    tick();

    // ---- PC wrap at 0xFFFF_FFFC ----
    i_stall           = 1'b1;
    tb_ack            = 1'b0;
    i_redirect_valid  = 1'b1;
    i_redirect_target = 32'hFFFF_FFFC;
    tick();
    i_redirect_valid = 1'b0;
    @(negedge clk);
    check("wrap_pc", o_pc, 32'hFFFF_FFFC);
    check("wrap_plus4", o_pc_plus4, 32'h0000_0000);
    i_stall = 1'b0;
    tb_ack  = 1'b1;
    push(32'hFFFF_FFFC, 32'h5A5A_5A59);
    tick();
    i_stall = 1'b1;
    tb_ack  = 1'b0;
    @(negedge clk);
    check("wrap_pc_after", o_pc, 32'h0000_0000);
    check("wrap_plus4_after", o_pc_plus4, 32'h0000_0004);

    // ---- Halt during a pending access, then reset out of HALT ----
    tick();
    i_stall = 1'b0;
    tick();
    i_halt = 1'b1;
    @(negedge clk);
    check("halt_req_pend", 32'(imem_bus.imem_req), 32'd1);
    check("halt_not_yet", 32'(o_halted), 32'd0);
    tick();
    tb_ack = 1'b1;
    push(32'h0000_0000, 32'hA5A5_A5A5);
    tick();
    tb_ack = 1'b0;
    @(negedge clk);
    check("halted", 32'(o_halted), 32'd1);
    check("halt_pc", o_pc, 32'h0000_0004);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("halt_no_req", 32'(imem_bus.imem_req), 32'd0);
    end
    tick();
    rst    = 1'b1;
    i_halt = 1'b0;
    tick();
    rst    = 1'b0;
    tb_ack = 1'b1;   // stray ack while in BOOT must be ignored
    @(negedge clk);
    check("rst2_pc", o_pc, 32'h0);
    check("rst2_halted", 32'(o_halted), 32'd0);
    check("rst2_boot_req", 32'(imem_bus.imem_req), 32'd0);
    tick();
    tb_ack = 1'b0;
    @(negedge clk);
    check("rst2_pc_kept", o_pc, 32'h0);
    check("rst2_req", 32'(imem_bus.imem_req), 32'd1);
    check("rst2_addr", imem_bus.imem_addr, 32'h0);
    tb_ack = 1'b1;
    push(32'h0000_0000, 32'hA5A5_A5A5);
    tick();
    tb_ack  = 1'b0;
    i_stall = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pc_fetch_unit
